// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch defaults and fetch FSM states.
// Imported by the fetch unit, its next-PC mux and the control decoder.
package cpu_pkg;

  localparam int ADDR_W_DEF = 12;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  typedef enum logic [1:0] {
    S_WARM = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sext17(
    input logic [16:0] imm
  );
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select for the fetch stage.
// Also flags an absolute jump that targets the current PC.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       q_imem,
  input  logic [31:0]       jr_target,
  input  logic              take_br,
  input  logic              is_rel,
  input  logic              is_jr,
  output logic [ADDR_W-1:0] pc_next,
  output logic              self_jump
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] rel_tgt;
  logic [ADDR_W-1:0] abs_tgt;
  logic [31:0]       off;
  logic              sel_jr;
  logic              sel_rel;
  logic              sel_abs;
  logic              sel_seq;
  logic              unused_bits;

  assign off     = sext17(q_imem[16:0]);
  assign pc_inc  = pc + ADDR_W'(1);
  assign rel_tgt = pc_inc + off[ADDR_W-1:0];
  assign abs_tgt = q_imem[ADDR_W-1:0];

  // One-hot selects: jr beats rel, rel beats absolute.
  assign sel_jr  = take_br & is_jr;
  assign sel_rel = take_br & is_rel & ~is_jr;
  assign sel_abs = take_br & ~is_rel & ~is_jr;
  assign sel_seq = ~take_br;

  always_comb begin
    pc_next = pc_inc;
    unique case (1'b1)
      sel_jr:  pc_next = jr_target[ADDR_W-1:0];
      sel_rel: pc_next = rel_tgt;
      sel_abs: pc_next = abs_tgt;
      sel_seq: pc_next = pc_inc;
      default: pc_next = pc_inc;
    endcase
  end

  assign self_jump   = sel_abs & (abs_tgt == pc);
  assign unused_bits = ^{q_imem, jr_target, off};

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, warm-up/run/halt FSM
// and a saturating count of committed redirects.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [31:0]       q_imem,
  input  logic              take_br,
  input  logic              is_rel,
  input  logic              is_jr,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] address_imem,
  output logic [31:0]       pc_plus1,
  output logic              insn_valid,
  output logic              redirect,
  output logic              halted,
  output logic [CNT_W-1:0]  redirect_cnt
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              self_jump;
  logic              run;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_mux (
    .pc        (pc),
    .q_imem    (q_imem),
    .jr_target (jr_target),
    .take_br   (take_br),
    .is_rel    (is_rel),
    .is_jr     (is_jr),
    .pc_next   (pc_next),
    .self_jump (self_jump)
  );

  assign run          = (state == S_RUN);
  assign pc_inc       = pc + ADDR_W'(1);
  assign address_imem = pc;
  assign pc_plus1     = {{(32-ADDR_W){1'b0}}, pc_inc};
  assign insn_valid   = run & ~stall;
  assign redirect     = run & ~stall & take_br;
  assign halted       = (state == S_HALT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_WARM;
      pc           <= ADDR_W'(RESET_PC);
      redirect_cnt <= '0;
    end else begin
      unique case (state)
        S_WARM: state <= S_RUN;
        S_RUN: begin
          if (!stall) begin
            pc <= pc_next;
            if (self_jump) state <= S_HALT;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_WARM;
      endcase
      if (redirect && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized check of pc_fetch_unit against a behavioural fetch model.
// Directed scenarios first, then random traffic with occasional resets.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 4;
  localparam int AMASK  = (1 << ADDR_W) - 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              stall = 1'b0;
  logic [31:0]       q_imem = '0;
  logic              take_br = 1'b0;
  logic              is_rel = 1'b0;
  logic              is_jr = 1'b0;
  logic [31:0]       jr_target = '0;
  logic [ADDR_W-1:0] address_imem;
  logic [31:0]       pc_plus1;
  logic              insn_valid;
  logic              redirect;
  logic              halted;
  logic [CNT_W-1:0]  redirect_cnt;

  pc_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (0),
    .CNT_W    (CNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .q_imem       (q_imem),
    .take_br      (take_br),
    .is_rel       (is_rel),
    .is_jr        (is_jr),
    .jr_target    (jr_target),
    .address_imem (address_imem),
    .pc_plus1     (pc_plus1),
    .insn_valid   (insn_valid),
    .redirect     (redirect),
    .halted       (halted),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // model: cycles since reset release decide warm-up, halt is sticky
  int m_pc;
  int m_cnt;
  bit m_warm;
  bit m_halt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // call at a negedge; leaves time just before the warm-up posedge
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_addr", 32'(address_imem), 32'd0);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_redir", 32'(redirect), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(redirect_cnt), 32'd0);
    #1;
    reset_n = 1'b1;
    m_pc = 0;
    m_cnt = 0;
    m_warm = 1'b1;
    m_halt = 1'b0;
  endtask

  function automatic int target(input bit rel, input bit jr,
                                input logic [31:0] q,
                                input logic [31:0] jt);
    int off;
    if (jr) return int'(jt) & AMASK;
    if (rel) begin
      off = int'(q[16:0]);
      if (q[16]) off = off - (1 << 17);
      return (m_pc + 1 + off) & AMASK;
    end
    return int'(q[26:0]) & AMASK;
  endfunction

  task automatic cyc(input bit st, input bit tb, input bit rl,
                     input bit j, input logic [31:0] q,
                     input logic [31:0] jt);
    bit run;
    int t;
    stall = st;
    take_br = tb;
    is_rel = rl;
    is_jr = j;
    q_imem = q;
    jr_target = jt;
    #1;
    run = !m_warm && !m_halt;
    chk("addr", 32'(address_imem), 32'(m_pc));
    chk("pc_plus1", pc_plus1, 32'((m_pc + 1) & AMASK));
    chk("valid", 32'(insn_valid), 32'(run && !st));
    chk("redirect", 32'(redirect), 32'(run && !st && tb));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("cnt", 32'(redirect_cnt), 32'(m_cnt));
    if (m_warm) begin
      m_warm = 1'b0;
    end else if (run && !st) begin
      if (tb) begin
        t = target(rl, j, q, jt);
        if (m_cnt < CMAX) m_cnt++;
        if (!rl && !j && t == m_pc) m_halt = 1'b1;
        m_pc = t;
      end else begin
        m_pc = (m_pc + 1) & AMASK;
      end
    end
    @(negedge clock);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic jr_to(input int a);
    cyc(0, 1, 0, 1, 32'h0, 32'(a));
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    // warm-up bubble then 0,1,2,3
    seq(5);
    chk("seq_pc4", 32'(address_imem), 32'd4);

    // relative branch back by three from 10
    jr_to(10);
    cyc(0, 1, 1, 0, 32'h0001_FFFD, 32'h0);
    chk("rel_pc8", 32'(address_imem), 32'd8);

    // jr truncation, stalled then taken; is_rel loses to is_jr
    jr_to(5);
    cyc(1, 1, 0, 1, 32'h0, 32'h1234);
    cyc(0, 1, 1, 1, 32'h0000_0003, 32'h1234);
    chk("jr_pc", 32'(address_imem), 32'h234);

    // wrap at the top of the address space
    jr_to(AMASK);
    seq(3);

    // absolute jump and a backward relative wrap
    cyc(0, 1, 0, 0, 32'h07FF_F123, 32'h0);
    jr_to(1);
    cyc(0, 1, 1, 0, 32'h0001_FFF0, 32'h0);

    // self-jump freezes fetch
    jr_to(7);
    cyc(0, 1, 0, 0, 32'h0000_0007, 32'h0);
    for (int i = 0; i < 10; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom, $urandom);
    chk("halt_pc7", 32'(address_imem), 32'd7);
    do_reset();
    seq(2);

    // counter saturation, then asynchronous clear
    for (int i = 0; i < (1 << CNT_W) + 2; i++)
      jr_to(100 + i);
    chk("cnt_sat", 32'(redirect_cnt), 32'(CMAX));
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] q;
      bit tb;
      bit rl;
      bit j;
      if ($urandom_range(0, 59) == 0) do_reset();
      q = $urandom;
      tb = ($urandom_range(0, 9) < 4);
      rl = 1'($urandom);
      j = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) begin
        q[11:0] = 12'(m_pc);
        tb = 1'b1;
        rl = 1'b0;
        j = 1'b0;
      end
      cyc($urandom_range(0, 3) == 0, tb, rl, j, q, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
